// File: rtl/sevenseg_pkg.sv
// Shared types and active-low segment glyphs ({g,f,e,d,c,b,a}) for the
// four-digit seven-segment display path.
package sevenseg_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [1:0] digit_idx_t;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decode; nibbles
// A..F render as a dash.
module bcd_to_seg
  import sevenseg_pkg::*;
(
  input  bcd_digit_t digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Four-digit multiplexed seven-segment driver capturing packed BCD on rdy rise.
// Optional leading-zero blanking: define LEADZERO_BLANK_EN.
module bcd_sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_d_in,
  input  logic        rdy,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [15:0]      held;
  logic             rdy_q;
  logic [DIV_W-1:0] div_cnt;
  digit_idx_t       idx;
  logic             tick;
  logic             load;
  logic             blank;
  bcd_digit_t       cur_digit;
  logic [6:0]       cur_seg;

  assign load = rdy & ~rdy_q;
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
      held  <= '0;
    end else begin
      rdy_q <= rdy;
      if (load) held <= bcd_d_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= idx + 1'b1;
    end
  end

  assign cur_digit = held[{idx, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

`ifdef LEADZERO_BLANK_EN
  // lead_zero[k]: every digit from k upward is zero; digit 0 always lit
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin
    lead_zero = '0;
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      lead_zero[k] = ((held >> (4 * k)) == 16'h0000);
    end
  end

  assign blank = lead_zero[idx];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= '1;
      dp  <= 1'b1;
    end else begin
      dp <= 1'b1;
      if (blank) begin
        seg <= SEG_OFF;
        an  <= '1;
      end else begin
        seg <= cur_seg;
        an  <= ~(4'b0001 << idx);
      end
    end
  end

endmodule
